// File: rtl/seg7_ctrl_pkg.sv
// Shared definitions for the 8-digit seven-segment controller:
// digit count, segment bit positions and the active-low hex glyph table.
package seg7_ctrl_pkg;

    localparam int unsigned SEG_DIGITS = 8;
    localparam int unsigned IDX_W      = $clog2(SEG_DIGITS);

    // Segment bus ordering is {dp,g,f,e,d,c,b,a}
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Active-low {g,f,e,d,c,b,a} patterns for 0-F
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
    import seg7_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_GLYPH[hex];

endmodule

// File: rtl/seg7_ctrl.sv
// Multiplexed 8-digit seven-segment display controller with CPU write port.
// Optional leading-zero blanking is built when SEG7_LZB_EN is defined.
module seg7_ctrl
    import seg7_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        seg_write,
    input  logic        seg_addr,
    input  logic [31:0] seg_wdata,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_ca,
    output logic [31:0] seg_value
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]    prescaler;
    logic             tick;
    logic [IDX_W-1:0] idx;
    logic [31:0]      value;
    logic [7:0]       en_mask;
    logic [7:0]       dp_mask;
    logic [3:0]       nibble;
    logic [6:0]       glyph;
    logic             show;
    logic [7:0]       an_next;
    logic [7:0]       ca_next;

    assign tick = (prescaler == PRESC_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (tick) begin
            prescaler <= '0;
            idx       <= idx + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Writes never touch the scan timing, so the refresh rate stays fixed
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value   <= '0;
            en_mask <= 8'hFF;
            dp_mask <= 8'h00;
        end else if (seg_write) begin
            if (!seg_addr) begin
                value <= seg_wdata;
            end else begin
                en_mask <= seg_wdata[7:0];
                dp_mask <= seg_wdata[15:8];
            end
        end
    end

    assign nibble = value[{idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .hex (nibble),
        .seg (glyph)
    );

    always_comb begin
        show = en_mask[idx];
`ifdef SEG7_LZB_EN
        // Digit 0 always shows so a zero value still displays "0"
        if ((idx != '0) && ((value >> {idx, 2'b00}) == 32'h0)) begin
            show = 1'b0;
        end
`endif
        an_next = show ? ~(8'h01 << idx) : 8'hFF;
        ca_next = 8'hFF;
        ca_next[SEG_G:SEG_A] = glyph;
        ca_next[SEG_DP]      = ~dp_mask[idx];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_an <= 8'hFF;
            seg_ca <= 8'hFF;
        end else begin
            seg_an <= an_next;
            seg_ca <= ca_next;
        end
    end

    assign seg_value = value;

endmodule
